// File: rtl/cap_sense_pkg.sv
// cap_sense_scanner shared types and defaults: scan FSM states and the
// default pad count, reading width and packing stride.
package cap_sense_pkg;

   localparam int DEF_NUM_PADS  = 9;
   localparam int DEF_READING_W = 32;
   localparam int PAD_STRIDE    = 32;

   typedef enum logic [1:0] {
      IDLE,
      DISCHARGE,
      CHARGE,
      PUBLISH
   } state_t;

   function automatic int pad_lsb(input int k);
      return k * PAD_STRIDE;
   endfunction

endpackage

// File: rtl/cap_sense_channel.sv
// One touch-pad channel: synchroniser, done flag, latched charge time.
// CAP_SENSE_FILTER_EN adds an IIR filter register on the published value.
module cap_sense_channel
   import cap_sense_pkg::*;
#(
   parameter int READING_W    = DEF_READING_W,
   parameter int CNT_W        = 16,
   parameter int FILTER_SHIFT = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 sense,
   input  logic                 charging,
   input  logic                 timeout,
   input  logic                 publish,
   input  logic [CNT_W-1:0]     count,
   output logic                 finished,
   output logic [READING_W-1:0] value
);

   logic [1:0]       sync;
   logic             done;
   logic [CNT_W-1:0] latch;
   logic             hit;
   logic [READING_W-1:0] sample;

   // at timeout count already equals the timeout value, so it fills in
   assign hit      = charging && !done && (sync[1] || timeout);
   assign finished = done || sync[1];
   assign sample   = READING_W'(latch);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync  <= '0;
         done  <= 1'b0;
         latch <= '0;
      end else begin
         sync <= {sync[0], sense};
         if (publish) begin
            done <= 1'b0;
         end else if (hit) begin
            done  <= 1'b1;
            latch <= count;
         end
      end
   end

`ifdef CAP_SENSE_FILTER_EN
   logic                        primed;
   logic [READING_W-1:0]        filt;
   logic signed [READING_W:0]   diff;
   logic signed [READING_W:0]   step;
   logic signed [READING_W:0]   nxt;

   always_comb begin
      diff  = signed'({1'b0, sample}) - signed'({1'b0, filt});
      step  = diff >>> FILTER_SHIFT;
      nxt   = signed'({1'b0, filt}) + step;
      value = primed ? nxt[READING_W-1:0] : sample;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         primed <= 1'b0;
         filt   <= '0;
      end else if (publish) begin
         primed <= 1'b1;
         filt   <= value;
      end
   end
`else
   assign value = sample;
`endif

endmodule

// File: rtl/cap_sense_scanner.sv
// Capacitive pad scanner: discharge/charge FSM with per-pad timing.
// Define CAP_SENSE_FILTER_EN to publish IIR-filtered readings.
module cap_sense_scanner
   import cap_sense_pkg::*;
#(
   parameter int NUM_PADS         = DEF_NUM_PADS,
   parameter int READING_W        = DEF_READING_W,
   parameter int DISCHARGE_CYCLES = 2000,
   parameter int TIMEOUT_CYCLES   = 65535,
   parameter int FILTER_SHIFT     = 3
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [NUM_PADS-1:0]           sense_in,
   output logic                          drive_out,
   output logic [NUM_PADS*READING_W-1:0] readings,
   output logic                          readings_valid
);

   localparam int DW = $clog2(DISCHARGE_CYCLES + 1);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_t            state;
   state_t            next;
   logic [DW-1:0]     dcnt;
   logic [CW-1:0]     ccnt;
   logic              charging;
   logic              publish;
   logic              timeout;
   logic [NUM_PADS-1:0] finished;
   logic [READING_W-1:0] value [NUM_PADS];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE:
            if (enable) next = DISCHARGE;
         DISCHARGE:
            if (dcnt == DW'(DISCHARGE_CYCLES - 1))
               next = CHARGE;
         CHARGE:
            if ((&finished) || timeout) next = PUBLISH;
         PUBLISH:
            next = enable ? DISCHARGE : IDLE;
         default:
            next = IDLE;
      endcase
   end

   always_comb begin
      charging  = (state == CHARGE);
      publish   = (state == PUBLISH);
      drive_out = charging;
      timeout   = charging && (ccnt == CW'(TIMEOUT_CYCLES));
   end

   // charge counter saturates at the timeout value
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dcnt <= '0;
         ccnt <= '0;
      end else begin
         dcnt <= (state == DISCHARGE) ? dcnt + DW'(1) : '0;
         if (!charging)    ccnt <= '0;
         else if (!timeout) ccnt <= ccnt + CW'(1);
      end
   end

   for (genvar k = 0; k < NUM_PADS; k++) begin : g_ch
      cap_sense_channel #(
         .READING_W    (READING_W),
         .CNT_W        (CW),
         .FILTER_SHIFT (FILTER_SHIFT)
      ) u_ch (
         .clock    (clock),
         .reset    (reset),
         .sense    (sense_in[k]),
         .charging (charging),
         .timeout  (timeout),
         .publish  (publish),
         .count    (ccnt),
         .finished (finished[k]),
         .value    (value[k])
      );
   end

   // all pads load together so a scan is never seen half-updated
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         readings       <= '0;
         readings_valid <= 1'b0;
      end else begin
         readings_valid <= publish;
         if (publish) begin
            for (int k = 0; k < NUM_PADS; k++)
               readings[pad_lsb(k) +: READING_W] <= value[k];
         end
      end
   end

endmodule

// File: doc/cap_sense_scanner.md
Name: cap_sense_scanner

Overview:
- Front-end that measures the capacitive touch pads. It drives the shared pad-excitation pin and times the RC charge of each pad.
- Publishes one 32-bit charge-time count per pad as a packed 288-bit bus (9 x 32). That bus feeds the processor's sensor read path and the RNG seed tap.
- A higher count means more capacitance, which indicates a touch.
- Scans free-run back to back while enabled.

Parameters:
- NUM_PADS, 9, number of sense inputs.
- READING_W, 32, width of each per-pad count.
- DISCHARGE_CYCLES, 2000, clock cycles the drive pin is held low before each charge phase.
- TIMEOUT_CYCLES, 65535, maximum charge-phase length; a pad that never goes high reports this value.
- FILTER_SHIFT, 3, IIR smoothing shift (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high = keep scanning; low = finish the current scan, then idle.
- sense_in  in  NUM_PADS  raw pad comparator inputs, asynchronous to clock.
- drive_out  out  1  shared excitation pin: 0 = discharge, 1 = charge.
- readings  out  NUM_PADS*READING_W  packed counts; pad k occupies bits [k*32+31 : k*32].
- readings_valid  out  1  one-cycle pulse when readings updates.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, drive_out=0, readings=0, readings_valid=0.
  - All counters and channel latches are cleared.
  - Asserting reset mid-scan aborts immediately; no partial publish occurs.
- Synchronisation: each sense_in bit passes through a 2-flop synchroniser before use. The synchroniser flops reset to 0.
- States: IDLE, DISCHARGE, CHARGE, PUBLISH.
- IDLE:
  - drive_out=0.
  - Go to DISCHARGE when enable=1.
- DISCHARGE:
  - drive_out=0.
  - Discharge counter runs from 0 to DISCHARGE_CYCLES-1, then go to CHARGE.
  - The phase lasts exactly DISCHARGE_CYCLES cycles.
- CHARGE:
  - drive_out=1.
  - Charge counter c starts at 0 on the first CHARGE cycle and increments by 1 each cycle.
  - Each channel latches c on the first CHARGE cycle its synchronised input is 1, then sets its done flag.
  - A latched value includes the 2-cycle synchroniser latency; no compensation is applied.
  - If a synchronised input is already 1 on the first CHARGE cycle (stuck-high or undischarged pad), that channel latches 0.
  - Exit to PUBLISH on the cycle all done flags are set, or when c reaches TIMEOUT_CYCLES, whichever comes first.
  - Channels not done at timeout latch TIMEOUT_CYCLES.
  - Later input transitions in the same scan are ignored, including glitches back to 0.
- PUBLISH (one cycle):
  - drive_out=0.
  - readings is loaded from the channel latches, zero-extended to READING_W, on the transition out of PUBLISH.
  - readings_valid is high for exactly the following cycle.
  - Done flags clear.
  - Next state is DISCHARGE if enable=1, else IDLE.
- enable semantics:
  - Sampled only in IDLE and PUBLISH.
  - Deasserting enable mid-DISCHARGE or mid-CHARGE completes the scan and publishes.
- Stability: readings holds between publishes. It never shows a partially updated scan, because all pads update in the same cycle.
- Counter widths:
  - The charge counter is wide enough for TIMEOUT_CYCLES and saturates there.
  - No wrap-around is possible.
  - TIMEOUT_CYCLES must be below 2^READING_W.
- Scan period: DISCHARGE_CYCLES + (charge cycles) + 1.

Optional Feature:
- Macro: CAP_SENSE_FILTER_EN.
- Defined: each published value becomes r_new = r_old + ((sample - r_old) >>> FILTER_SHIFT), using signed arithmetic in READING_W+1 bits.
  - The first publish after reset loads the raw sample directly, with no filtering.
- Undefined: raw samples are published. No filter registers are synthesised.

Decomposition:
- Package cap_sense_pkg holds:
  - the state enum (IDLE, DISCHARGE, CHARGE, PUBLISH);
  - NUM_PADS and READING_W defaults;
  - the packing helper constant for the pad stride (32).
- Sub-module cap_sense_channel, instantiated NUM_PADS times. It contains:
  - the 2-flop synchroniser;
  - the done flag;
  - the latched count register, including timeout fill;
  - the optional filter register.
- The FSM, discharge counter and charge counter live in the top level.

Test Plan:
- Bench parameters: DISCHARGE_CYCLES=4, TIMEOUT_CYCLES=100.
- Reset and start: hold reset=0, then release with enable=1.
  - drive_out=0 for exactly 4 cycles after leaving IDLE, then 1.
  - readings=0 until the first readings_valid.
- Staggered pads: pad k raises sense_in 10+5k cycles after drive_out rises.
  - readings for pad k = 12+5k (2-cycle synchroniser latency); pad 8 = 52.
  - PUBLISH occurs the cycle after pad 8 is done.
  - readings_valid is high for one cycle.
- Timeout: pad 3 held low, others rise at 10.
  - Pad 3 = 100; others = 12.
  - CHARGE lasts 101 cycles.
- Stuck-high and glitch:
  - Pad 0 held high throughout → 0.
  - Pad 1 rises at 20, drops at 25, rises at 40 → 22.
- Enable and reset mid-scan:
  - Drop enable mid-CHARGE → scan publishes, then IDLE with drive_out=0.
  - Assert reset mid-CHARGE → immediate drive_out=0, readings=0, no valid pulse.
- Filter (CAP_SENSE_FILTER_EN, FILTER_SHIFT=3): pad 0 samples 80 then 16 → published 80 then 72.
